paddle_engine: RTL and testbench

- Parametrised paddle controller and pixel generator for the pong VGA path. Replaces the fixed top-paddle control/datapath pair.
- Each frame it does the following, one pixel per clock on the shared VGA write port:
  - erases the paddle rectangle at its old position and old width;
  - waits a programmable move interval and applies one clamped step left or right;
  - redraws the rectangle at the new position and current width.
- Generalised over paddle height, step size, bounds, timing and colour. One instance serves either top or bottom paddle.

---
 rtl/paddle_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_paddle_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_engine.sv
// paddle_engine
//   Paddle controller and pixel generator for the pong VGA path. Each frame
//   erases the paddle at its old origin/width, waits a programmable move
//   interval, applies one clamped step, then redraws at the new origin with
//   the width latched at go. One pixel per clock on the shared write port.
//
// Optional feature macro: PADDLE_AI_TRACK_EN
//   Adds ai_mode/target_x. With ai_mode=1 the direction comes from comparing
//   target_x to the paddle centre instead of left/right.
//
// Ports
//   clk             system clock
//   resetn          synchronous active-low reset
//   go              start one frame (sampled only in IDLE)
//   left, right     move requests (sampled in the MOVE cycle)
//   paddle_width    extra pixels beyond origin (drawn width = value + 1)
//   ai_mode         (PADDLE_AI_TRACK_EN only) select target tracking
//   target_x        (PADDLE_AI_TRACK_EN only) column to track
//   writeEn         pixel write strobe
//   x_out, y_out    pixel coordinates (valid while writeEn = 1)
//   color_out       pixel colour (0 while erasing, COLOR while drawing)
//   x_paddle_origin committed origin, for collision logic
//   busy            high in every state except IDLE
//   done            high throughout DONE
module paddle_engine #(
  parameter int unsigned X_INIT        = 75,
  parameter int unsigned Y_POS         = 12,
  parameter int unsigned X_MIN         = 51,
  parameter int unsigned X_MAX         = 110,
  parameter int unsigned HEIGHT        = 1,
  parameter int unsigned STEP          = 1,
  parameter int unsigned MOVE_CYCLES   = 10000000,
  parameter int unsigned SETTLE_CYCLES = 32,
  parameter logic [2:0]  COLOR         = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       left,
  input  logic       right,
  input  logic [3:0] paddle_width,
`ifdef PADDLE_AI_TRACK_EN
  input  logic       ai_mode,
  input  logic [7:0] target_x,
`endif
  output logic       writeEn,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic [7:0] x_paddle_origin,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TMAX = (MOVE_CYCLES > SETTLE_CYCLES) ? MOVE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] MOVE_LAST   = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    ROW_LAST    = 3'(HEIGHT - 1);

  // Signed 10-bit working range so that neither origin+STEP nor X_MAX-width
  // can wrap at any boundary.
  localparam logic signed [9:0] XMIN_S = 10'(X_MIN);
  localparam logic signed [9:0] XMAX_S = 10'(X_MAX);
  localparam logic signed [9:0] STEP_S = 10'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE_WAIT,
    S_MOVE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [7:0]    x_pos_q;
  logic [7:0]    x_pos_d;
  logic [3:0]    w_drawn_q;
  logic [3:0]    w_new_q;
  logic [3:0]    col_q;
  logic [2:0]    row_q;
  logic [TW-1:0] timer_q;
  logic          writeEn_q;
  logic          busy_q;
  logic          done_q;
  logic [2:0]    color_q;

  logic          col_last;
  logic          row_last;
  logic          mv_left;
  logic          mv_right;

  logic signed [9:0] cur_s;
  logic signed [9:0] rlim;
  logic signed [9:0] cand;

  assign col_last = (col_q == w_drawn_q);
  assign row_last = (row_q == ROW_LAST);

  // Direction select
`ifdef PADDLE_AI_TRACK_EN
  logic [9:0] centre;
  always_comb begin
    centre   = {2'b00, x_pos_q} + {7'b0, w_new_q[3:1]};
    mv_left  = left;
    mv_right = right;
    if (ai_mode) begin
      mv_right = ({2'b00, target_x} > centre);
      mv_left  = ({2'b00, target_x} < centre);
    end
  end
`else
  always_comb begin
    mv_left  = left;
    mv_right = right;
  end
`endif

  // Clamped step. The right limit is applied even with no request so that a
  // wider paddle is pulled back inside X_MAX; an impossible right limit
  // (below X_MIN) pins the origin to X_MIN.
  always_comb begin
    cur_s = $signed({2'b00, x_pos_q});
    rlim  = XMAX_S - $signed({6'b000000, w_new_q});
    cand  = cur_s;
    if (mv_right && !mv_left) begin
      cand = cur_s + STEP_S;
    end else if (mv_left && !mv_right) begin
      cand = cur_s - STEP_S;
      if (cand < XMIN_S) cand = XMIN_S;
    end
    if (cand > rlim) cand = rlim;
    if (rlim < XMIN_S) cand = XMIN_S;
    x_pos_d = cand[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      x_pos_q   <= 8'(X_INIT);
      w_drawn_q <= '0;
      w_new_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      timer_q   <= '0;
      writeEn_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      color_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            w_new_q   <= paddle_width;
            state_q   <= S_ERASE;
            writeEn_q <= 1'b1;
            busy_q    <= 1'b1;
            color_q   <= '0;
          end
        end

        S_ERASE: begin
          if (col_last) begin
            col_q <= '0;
            if (row_last) begin
              row_q     <= '0;
              state_q   <= S_MOVE_WAIT;
              writeEn_q <= 1'b0;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            col_q <= col_q + 4'd1;
          end
        end

        S_MOVE_WAIT: begin
          if (timer_q == MOVE_LAST) begin
            timer_q <= '0;
            state_q <= S_MOVE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_MOVE: begin
          x_pos_q   <= x_pos_d;
          w_drawn_q <= w_new_q;
          state_q   <= S_DRAW;
          writeEn_q <= 1'b1;
          color_q   <= COLOR;
        end

        S_DRAW: begin
          if (col_last) begin
            col_q <= '0;
            if (row_last) begin
              row_q     <= '0;
              state_q   <= S_DONE;
              writeEn_q <= 1'b0;
              color_q   <= '0;
              done_q    <= 1'b1;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            col_q <= col_q + 4'd1;
          end
        end

        S_DONE: begin
          if (timer_q == SETTLE_LAST) begin
            timer_q <= '0;
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          writeEn_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          color_q   <= '0;
        end
      endcase
    end
  end

  assign writeEn         = writeEn_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign color_out       = color_q;
  assign x_out           = x_pos_q + {4'b0000, col_q};
  assign y_out           = 7'(Y_POS) + {4'b0000, row_q};
  assign x_paddle_origin = x_pos_q;

endmodule

// File: tb/tb_paddle_engine.sv
// Bench for paddle_engine: a frame-level reference model expands each go into
// the full expected per-cycle trace (pixels, strobes, origin), and a negedge
// compare process checks the DUT against it every cycle. Directed frames pin
// clamps, width changes, latency and mid-frame reset with literal values;
// a randomized phase follows.
module tb_paddle_engine;

  localparam int XI  = 75;
  localparam int YP  = 12;
  localparam int XMN = 51;
  localparam int XMX = 110;
  localparam int H   = 3;
  localparam int ST  = 3;
  localparam int MC  = 5;
  localparam int SC  = 6;
  localparam logic [2:0] COL = 3'b010;

  logic       clk = 1'b0;
  logic       resetn, go, left, right;
  logic [3:0] paddle_width;
  logic       writeEn, busy, done;
  logic [7:0] x_out, x_paddle_origin;
  logic [6:0] y_out;
  logic [2:0] color_out;
`ifdef PADDLE_AI_TRACK_EN
  logic       ai_mode = 1'b0;
  logic [7:0] target_x = 8'd0;
`endif

  paddle_engine #(
    .X_INIT(XI), .Y_POS(YP), .X_MIN(XMN), .X_MAX(XMX), .HEIGHT(H), .STEP(ST),
    .MOVE_CYCLES(MC), .SETTLE_CYCLES(SC), .COLOR(COL)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .left(left), .right(right),
    .paddle_width(paddle_width),
`ifdef PADDLE_AI_TRACK_EN
    .ai_mode(ai_mode), .target_x(target_x),
`endif
    .writeEn(writeEn), .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .x_paddle_origin(x_paddle_origin), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit armed   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit we; int x; int y; int c; bit busy; bit done; int org; bit first;
  } exp_t;

  exp_t q[$];
  int mx = XI;   // committed origin
  int mw = 0;    // width currently on screen

  function automatic exp_t rec(bit we, int x, int y, int c, bit b, bit d, int org);
    exp_t e;
    e.we = we; e.x = x; e.y = y; e.c = c; e.busy = b; e.done = d; e.org = org; e.first = 1'b0;
    return e;
  endfunction

  task automatic build_frame();
    int wn, rl, nx, ctr;
    bit l, r;
    exp_t e;
    wn = int'(paddle_width);
    l  = left;
    r  = right;
`ifdef PADDLE_AI_TRACK_EN
    if (ai_mode) begin
      ctr = mx + (wn / 2);
      r = int'(target_x) > ctr;
      l = int'(target_x) < ctr;
    end
`else
    ctr = 0;
`endif
    for (int row = 0; row < H; row++)
      for (int c = 0; c <= mw; c++)
        q.push_back(rec(1, mx + c, YP + row, 0, 1, 0, mx));
    for (int i = 0; i < MC + 1; i++) q.push_back(rec(0, 0, 0, 0, 1, 0, mx));
    rl = XMX - wn;
    if (r && !l)      nx = (mx + ST < rl) ? mx + ST : rl;
    else if (l && !r) nx = (mx - ST > XMN) ? mx - ST : XMN;
    else              nx = mx;
    if (nx > rl)  nx = rl;
    if (rl < XMN) nx = XMN;
    for (int row = 0; row < H; row++)
      for (int c = 0; c <= wn; c++)
        q.push_back(rec(1, nx + c, YP + row, int'(COL), 1, 0, nx));
    for (int i = 0; i < SC; i++) q.push_back(rec(0, 0, 0, 0, 1, 1, nx));
    e = q[0]; e.first = 1'b1; q[0] = e;
    mx = nx;
    mw = wn;
  endtask

  always @(posedge clk) begin
    bit was_idle;
    cyc++;
    was_idle = (q.size() == 0);
    if (!resetn) begin
      q.delete();
      mx = XI;
      mw = 0;
    end else begin
      if (!was_idle) void'(q.pop_front());
      if (was_idle && go) build_frame();
    end
  end

  // ---------------- compare process ----------------
  int er_cnt, er_min, er_max, dr_cnt, dr_min, dr_max;

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (q.size() != 0) e = q[0];
      else               e = rec(0, 0, 0, 0, 0, 0, mx);
      if (e.first) begin
        er_cnt = 0; er_min = 999; er_max = -1;
        dr_cnt = 0; dr_min = 999; dr_max = -1;
      end
      chk("writeEn", int'(writeEn), int'(e.we));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("origin", int'(x_paddle_origin), e.org);
      if (e.we) begin
        chk("x_out", int'(x_out), e.x);
        chk("y_out", int'(y_out), e.y);
        chk("color_out", int'(color_out), e.c);
      end
      if (writeEn) begin
        if (color_out == 3'b000) begin
          er_cnt++;
          if (int'(x_out) < er_min) er_min = int'(x_out);
          if (int'(x_out) > er_max) er_max = int'(x_out);
        end else begin
          dr_cnt++;
          if (int'(x_out) < dr_min) dr_min = int'(x_out);
          if (int'(x_out) > dr_max) dr_max = int'(x_out);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // lat = number of cycles from the go-sampling IDLE cycle to done rising,
  // or -1 if the frame was aborted by a random reset.
  task automatic frame(input int pw, input bit l, input bit r, input bit noise, output int lat);
    int n;
    @(posedge clk); #1;
    paddle_width = 4'(pw); left = l; right = r; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    lat = 1;
    while (!done && lat < 1000) begin
      if (noise) begin
        paddle_width = 4'($urandom_range(0, 15));
        go = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        if ($urandom_range(0, 47) == 0) begin
          resetn = 1'b0; go = 1'b0;
          @(posedge clk); #1;
          resetn = 1'b1;
          lat = -1;
          break;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 1000) chk("done_timeout", 1, 0);
    n = 0;
    while (busy && n < 1000) begin
      go = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    go = 1'b0;
    if (n >= 1000) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int lat, k;
    resetn = 1'b0; go = 1'b0; left = 1'b0; right = 1'b0; paddle_width = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_writeEn", int'(writeEn), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_color", int'(color_out), 0);
    chk("rst_x_out", int'(x_out), 75);
    chk("rst_y_out", int'(y_out), 12);
    chk("rst_origin", int'(x_paddle_origin), 75);
    armed = 1'b1;
    resetn = 1'b1;

    // First frame: width 3, no move.
    frame(3, 0, 0, 0, lat);
    chk("lat_first", lat, 22);
    chk("first_origin", int'(x_paddle_origin), 75);
    chk("first_erase_cnt", er_cnt, 3);
    chk("first_erase_x", er_min, 75);
    chk("first_draw_cnt", dr_cnt, 12);
    chk("first_draw_min", dr_min, 75);
    chk("first_draw_max", dr_max, 78);

    // Step right until the right clamp (110-3 = 107).
    frame(3, 0, 1, 0, lat);
    chk("right_one", int'(x_paddle_origin), 78);
    for (int i = 0; i < 10; i++) frame(3, 0, 1, 0, lat);
    chk("right_clamp", int'(x_paddle_origin), 107);

    // Width grows to 15: old extent erased, origin forced to 95.
    frame(15, 0, 0, 0, lat);
    chk("grow_erase_cnt", er_cnt, 12);
    chk("grow_erase_min", er_min, 107);
    chk("grow_erase_max", er_max, 110);
    chk("grow_origin", int'(x_paddle_origin), 95);
    chk("grow_draw_min", dr_min, 95);
    chk("grow_draw_max", dr_max, 110);
    chk("grow_draw_cnt", dr_cnt, 48);
    chk("lat_grow", lat, 67);
    frame(15, 0, 1, 0, lat);
    chk("at_xmax", int'(x_paddle_origin), 95);

    // Step left to the left clamp without wrap.
    for (int i = 0; i < 14; i++) frame(0, 1, 0, 0, lat);
    chk("left_53", int'(x_paddle_origin), 53);
    frame(0, 1, 0, 0, lat);
    chk("left_clamp", int'(x_paddle_origin), 51);
    frame(0, 1, 1, 0, lat);
    chk("both_dirs", int'(x_paddle_origin), 51);

    // Reset on the 5th DRAW cycle of a width-2 frame.
    @(posedge clk); #1;
    paddle_width = 4'd2; left = 1'b0; right = 1'b0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    k = 0;
    while (!(writeEn && color_out == COL) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) chk("draw_timeout", 1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("draw5_x", int'(x_out), 52);
    chk("draw5_y", int'(y_out), 13);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_writeEn", int'(writeEn), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_origin", int'(x_paddle_origin), 75);
    resetn = 1'b1;

`ifdef PADDLE_AI_TRACK_EN
    ai_mode = 1'b1;
    target_x = 8'd120;
    for (int i = 0; i < 12; i++) frame(3, 1, 0, 0, lat);
    chk("ai_right_clamp", int'(x_paddle_origin), 107);
    target_x = 8'd10;
    for (int i = 0; i < 20; i++) frame(3, 0, 1, 0, lat);
    chk("ai_left_clamp", int'(x_paddle_origin), 51);
    ai_mode = 1'b0;
`endif

    // Randomized frames with go/width noise and occasional reset.
    for (int i = 0; i < 60; i++) begin
`ifdef PADDLE_AI_TRACK_EN
      ai_mode = 1'($urandom_range(0, 1));
      target_x = 8'($urandom_range(0, 255));
`endif
      frame($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
